// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target.
// Contents:
//   spi_target_state_t - target FSM states
//   BIT_MSB            - bit counter start value (MSB-first byte)
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StNext
  } spi_target_state_t;

  localparam logic [2:0] BIT_MSB = 3'd7;

endpackage

// File: rtl/spi_target_if.sv
// Bus bundle between an SPI target and its surroundings: the SPI pins plus
// the byte-buffer access port.
// Signals:
//   sclk, mosi, cs_n  - SPI pins driven by the controller
//   miso              - SPI data back to the controller
//   data_in           - buffer read data at address (combinational)
//   data_out, wr      - received byte and its one-cycle write strobe
//   address           - byte index within the current frame
//   done, count       - frame-end pulse and whole-byte count of the frame
//   overflow          - frame ran past the buffer (limit build only)
// Modports: master (environment side), slave (spi_target side).
interface spi_target_if #(
  parameter int unsigned MEMORY_SIZE_IN_BYTES = 64
);
  localparam int unsigned AW = (MEMORY_SIZE_IN_BYTES > 1) ? $clog2(MEMORY_SIZE_IN_BYTES) : 1;

  logic          sclk;
  logic          mosi;
  logic          cs_n;
  logic          miso;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          wr;
  logic [AW-1:0] address;
  logic          done;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output sclk, mosi, cs_n, data_in,
    input  miso, data_out, wr, address, done, count, overflow
  );

  modport slave (
    input  sclk, mosi, cs_n, data_in,
    output miso, data_out, wr, address, done, count, overflow
  );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer with optional registered edge pulses.
// Ports:
//   clk, rst   - system clock, async active-high reset
//   d_i        - asynchronous input
//   q_o        - synchronized level
//   rise_o     - one-cycle pulse on a rising synchronized edge (0 if EdgeEn = 0)
//   fall_o     - one-cycle pulse on a falling synchronized edge (0 if EdgeEn = 0)
// ResetVal should match the idle level of the pin so reset release does not
// fabricate an edge.
module spi_sync #(
  parameter bit EdgeEn   = 1'b1,
  parameter bit ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], d_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

  if (EdgeEn) begin : g_edge
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
      prev_d = sync_q[1];
      rise_d = sync_q[1] & ~prev_q;
      fall_d = ~sync_q[1] & prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev_q <= ResetVal;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        prev_q <= prev_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target running on the system clock. sclk, mosi and cs_n are
// oversampled; every received byte is written to a byte buffer while the
// buffer byte at the same index is shifted back out on miso.
// Ports:
//   clk, rst - system clock, async active-high reset
//   bus      - spi_target_if.slave (SPI pins, buffer port, frame status)
// Build option: SPI_TARGET_LIMIT_EN - stop writing once a frame has filled
// the buffer, saturate address, send 0xFF and flag overflow until the next
// frame starts. Without it address wraps and overflow stays 0.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE_IN_BYTES = 64
) (
  input logic         clk,
  input logic         rst,
  spi_target_if.slave bus
);

  localparam int unsigned AW = (MEMORY_SIZE_IN_BYTES > 1) ? $clog2(MEMORY_SIZE_IN_BYTES) : 1;
  localparam logic [AW-1:0] LastAddr = AW'(MEMORY_SIZE_IN_BYTES - 1);

  // Synchronized pins and event pulses
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync #(.EdgeEn(1'b1), .ResetVal(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .d_i   (bus.sclk),
    .q_o   (sclk_lvl),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_sync #(.EdgeEn(1'b0), .ResetVal(1'b0)) u_mosi_sync (
    .clk   (clk),
    .rst   (rst),
    .d_i   (bus.mosi),
    .q_o   (mosi_s),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  spi_sync #(.EdgeEn(1'b1), .ResetVal(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .d_i   (bus.cs_n),
    .q_o   (cs_lvl),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  // State
  spi_target_state_t state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic              miso_q, miso_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     address_q, address_d;
  logic              done_q, done_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;

  logic          wr_allow;
  logic [7:0]    load_byte;
  logic [AW-1:0] address_next;
  logic [AW:0]   count_inc;

  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

  // count_q holds the number of bytes already finished in this frame, i.e.
  // the index of the byte currently being loaded or shifted.
`ifdef SPI_TARGET_LIMIT_EN
  localparam logic [AW:0] MemBytes = (AW + 1)'(MEMORY_SIZE_IN_BYTES);

  assign wr_allow     = (count_q < MemBytes);
  assign load_byte    = (count_q < MemBytes) ? bus.data_in : 8'hFF;
  assign address_next = (address_q == LastAddr) ? address_q : address_q + 1'b1;
`else
  assign wr_allow     = 1'b1;
  assign load_byte    = bus.data_in;
  assign address_next = (address_q == LastAddr) ? '0 : address_q + 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_byte_d  = tx_byte_q;
    rx_sr_d    = rx_sr_q;
    miso_d     = miso_q;
    data_out_d = data_out_q;
    wr_d       = 1'b0;
    address_d  = address_q;
    done_d     = 1'b0;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          address_d  = '0;
          bit_cnt_d  = BIT_MSB;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        tx_byte_d = load_byte;
        miso_d    = load_byte[7];
        state_d   = StShift;
      end
      StShift: begin
        if (sclk_rise) begin
          rx_sr_d   = {rx_sr_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            data_out_d = {rx_sr_q[6:0], mosi_s};
            bit_cnt_d  = BIT_MSB;
            wr_d       = wr_allow;
            if (!wr_allow) begin
              overflow_d = 1'b1;
            end
            state_d = StNext;
          end
        end else if (sclk_fall && bit_cnt_q != BIT_MSB) begin
          // The MSB was already driven in StLoad; later bits follow each fall.
          miso_d = tx_byte_q[bit_cnt_q];
        end
      end
      StNext: begin
        count_d   = count_inc;
        address_d = address_next;
        state_d   = StLoad;
      end
      default: state_d = StIdle;
    endcase

    // Frame end overrides everything; a byte finishing in StNext keeps its
    // write (wr_q is already high) and its count increment.
    if (state_q != StIdle && cs_rise) begin
      state_d   = StIdle;
      bit_cnt_d = BIT_MSB;
      miso_d    = 1'b0;
      wr_d      = 1'b0;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= BIT_MSB;
      tx_byte_q  <= 8'h00;
      rx_sr_q    <= 8'h00;
      miso_q     <= 1'b0;
      data_out_q <= 8'h00;
      wr_q       <= 1'b0;
      address_q  <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_byte_q  <= tx_byte_d;
      rx_sr_q    <= rx_sr_d;
      miso_q     <= miso_d;
      data_out_q <= data_out_d;
      wr_q       <= wr_d;
      address_q  <= address_d;
      done_q     <= done_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.data_out = data_out_q;
  assign bus.wr       = wr_q;
  assign bus.address  = address_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target with a 4-byte buffer. Frame-level vectors
// (bytes sent, buffer contents, expected writes/miso/count) drive a loop;
// hand-written sequences cover overflow clearing and async reset mid-byte.
// Expectations follow SPI_TARGET_LIMIT_EN when the bench is built with it.
module tb_spi_target;

  localparam int unsigned MemSize = 4;

  logic clk;
  logic rst;

  spi_target_if #(.MEMORY_SIZE_IN_BYTES(MemSize)) bus ();

  spi_target #(.MEMORY_SIZE_IN_BYTES(MemSize)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only buffer model behind data_in
  logic [7:0] mem [MemSize];
  always_comb bus.data_in = mem[bus.address];

  // Write / done monitor
  int         wr_n = 0;
  int         done_n = 0;
  logic [1:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [2:0] done_count = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr) begin
        if (wr_n < 64) begin
          wr_addr_log[wr_n] = bus.address;
          wr_data_log[wr_n] = bus.data_out;
        end
        wr_n++;
      end
      if (bus.done) begin
        done_count = bus.count;
        done_n++;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int               nbytes;
    int               abort_bits;
    logic [0:5][7:0]  tx;
    logic [0:3][7:0]  mem;
    int               exp_nwr;
    logic [0:5][1:0]  exp_addr;
    logic [0:5][7:0]  exp_miso;
    logic [2:0]       exp_count;
    logic             exp_ovf;
  } vec_t;

  vec_t            vecs [4];
  logic [0:5][7:0] got_miso;

  // Whole frame: cs_n low, 16 clk per sclk period, MSB first; extra_bits
  // partial bits of tx[nbytes] precede the cs_n rise.
  task automatic run_frame(input logic [0:5][7:0] tx, input int nbytes, input int extra_bits);
    int total;
    int i;
    int b;
    total = nbytes * 8 + extra_bits;
    bus.cs_n = 1'b0;
    for (int k = 0; k < total; k++) begin
      i = k / 8;
      b = 7 - (k % 8);
      bus.mosi = tx[i][b];
      repeat (8) @(negedge clk);
      got_miso[i][b] = bus.miso;
      bus.sclk = 1'b1;
      repeat (8) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " miso"}, 32'(bus.miso), 32'h0);
    check({tag, " data_out"}, 32'(bus.data_out), 32'h0);
    check({tag, " wr"}, 32'(bus.wr), 32'h0);
    check({tag, " address"}, 32'(bus.address), 32'h0);
    check({tag, " done"}, 32'(bus.done), 32'h0);
    check({tag, " count"}, 32'(bus.count), 32'h0);
    check({tag, " overflow"}, 32'(bus.overflow), 32'h0);
  endtask

  task automatic run_vector(input int v);
    int wr_base;
    int done_base;
    for (int m = 0; m < 4; m++) mem[m] = vecs[v].mem[m];
    wr_base   = wr_n;
    done_base = done_n;
    run_frame(vecs[v].tx, vecs[v].nbytes, vecs[v].abort_bits);
    check($sformatf("v%0d done pulses", v), 32'(done_n - done_base), 32'd1);
    check($sformatf("v%0d count at done", v), 32'(done_count), 32'(vecs[v].exp_count));
    check($sformatf("v%0d count held", v), 32'(bus.count), 32'(vecs[v].exp_count));
    check($sformatf("v%0d overflow", v), 32'(bus.overflow), 32'(vecs[v].exp_ovf));
    check($sformatf("v%0d wr count", v), 32'(wr_n - wr_base), 32'(vecs[v].exp_nwr));
    for (int j = 0; j < vecs[v].exp_nwr; j++) begin
      check($sformatf("v%0d wr%0d address", v, j), 32'(wr_addr_log[wr_base + j]),
            32'(vecs[v].exp_addr[j]));
      check($sformatf("v%0d wr%0d data", v, j), 32'(wr_data_log[wr_base + j]),
            32'(vecs[v].tx[j]));
    end
    for (int i = 0; i < vecs[v].nbytes; i++) begin
      check($sformatf("v%0d miso byte%0d", v, i), 32'(got_miso[i]), 32'(vecs[v].exp_miso[i]));
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.cs_n = 1'b1;
    for (int m = 0; m < 4; m++) mem[m] = 8'h00;

    // Single byte
    vecs[0].nbytes     = 1;
    vecs[0].abort_bits = 0;
    vecs[0].tx         = {8'h3C, 40'h0};
    vecs[0].mem        = {8'hA5, 8'h00, 8'h00, 8'h00};
    vecs[0].exp_nwr    = 1;
    vecs[0].exp_addr   = {2'd0, 10'd0};
    vecs[0].exp_miso   = {8'hA5, 40'h0};
    vecs[0].exp_count  = 3'd1;
    vecs[0].exp_ovf    = 1'b0;
    // Three bytes
    vecs[1].nbytes     = 3;
    vecs[1].abort_bits = 0;
    vecs[1].tx         = {8'h01, 8'h02, 8'h03, 24'h0};
    vecs[1].mem        = {8'h11, 8'h22, 8'h33, 8'h44};
    vecs[1].exp_nwr    = 3;
    vecs[1].exp_addr   = {2'd0, 2'd1, 2'd2, 6'd0};
    vecs[1].exp_miso   = {8'h11, 8'h22, 8'h33, 24'h0};
    vecs[1].exp_count  = 3'd3;
    vecs[1].exp_ovf    = 1'b0;
    // Abort after 4 bits of byte 2
    vecs[2].nbytes     = 1;
    vecs[2].abort_bits = 4;
    vecs[2].tx         = {8'h5A, 8'hC3, 32'h0};
    vecs[2].mem        = {8'h96, 8'h3C, 8'h00, 8'h00};
    vecs[2].exp_nwr    = 1;
    vecs[2].exp_addr   = {2'd0, 10'd0};
    vecs[2].exp_miso   = {8'h96, 40'h0};
    vecs[2].exp_count  = 3'd1;
    vecs[2].exp_ovf    = 1'b0;
    // Six bytes into a four-byte buffer
    vecs[3].nbytes     = 6;
    vecs[3].abort_bits = 0;
    vecs[3].tx         = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    vecs[3].mem        = {8'h80, 8'h81, 8'h82, 8'h83};
    vecs[3].exp_count  = 3'd6;
`ifdef SPI_TARGET_LIMIT_EN
    vecs[3].exp_nwr    = 4;
    vecs[3].exp_addr   = {2'd0, 2'd1, 2'd2, 2'd3, 4'd0};
    vecs[3].exp_miso   = {8'h80, 8'h81, 8'h82, 8'h83, 8'hFF, 8'hFF};
    vecs[3].exp_ovf    = 1'b1;
`else
    vecs[3].exp_nwr    = 6;
    vecs[3].exp_addr   = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    vecs[3].exp_miso   = {8'h80, 8'h81, 8'h82, 8'h83, 8'h80, 8'h81};
    vecs[3].exp_ovf    = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_vector(v);
      repeat (4) @(negedge clk);
    end

    // Overflow (if any) is still held after the frame, cleared by the next cs_n fall
    check("overflow held after frame", 32'(bus.overflow), 32'(vecs[3].exp_ovf));
    check("data_out after frame", 32'(bus.data_out), 32'h15);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("overflow cleared on cs_n fall", 32'(bus.overflow), 32'h0);
    check("count cleared on cs_n fall", 32'(bus.count), 32'h0);

    // Async reset in the middle of a byte
    for (int k = 0; k < 3; k++) begin
      bus.mosi = 1'b1;
      repeat (8) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (8) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async reset");
    repeat (3) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rst      = 1'b0;
    repeat (6) @(negedge clk);

    // The next frame after reset behaves normally
    run_vector(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (peripheral), mode 0 (CPOL = 0, CPHA = 0). It is the far end of the `spi_controller` link. Runs on the system clock and oversamples `sclk`, `mosi` and `cs_n` through synchronizers. Each received byte is written to a byte-addressed buffer. In the same full-duplex frame, bytes read from that buffer are shifted out on `miso`.

## Interface
- `MEMORY_SIZE_IN_BYTES`, default 64: buffer depth. AW = $clog2(MEMORY_SIZE_IN_BYTES).
- `clk` input 1: system clock; all state on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `sclk` input 1: SPI clock from controller; asynchronous to `clk`.
- `mosi` input 1: serial data in, MSB first.
- `cs_n` input 1: active-low chip select; frames a transfer.
- `miso` output 1: serial data out, MSB first.
- `data_in` input 8: buffer read data at `address`, combinational.
- `data_out` output 8: last complete received byte.
- `wr` output 1: one-cycle write strobe for `data_out` at `address`.
- `address` output AW: current byte index in frame.
- `done` output 1: one-cycle pulse at frame end.
- `count` output AW+1: whole bytes received in last frame; valid with `done`, held until next frame.
- `overflow` output 1: see Configuration; constant 0 when the feature is compiled out.

## Operation
- Inputs `sclk`, `mosi`, `cs_n` each pass a 2-flop synchronizer.
- Rise and fall events on `sclk`/`cs_n` are one-cycle pulses from sync-stage compare.
- FSM states: IDLE, LOAD, SHIFT, NEXT.
  - **IDLE**: `miso` = 0. A `cs_n` fall event sets `address` = 0, `bit_cnt` = 7 and `count` = 0, then moves to LOAD.
  - **LOAD** (1 cycle): `tx_byte <= data_in`, `miso <= data_in[7]`, then moves to SHIFT.
  - **SHIFT**:
    - `sclk` rise: `rx_sr <= {rx_sr[6:0], mosi_sync}` and `bit_cnt` decrements. When `bit_cnt` was 0: `data_out <= {rx_sr[6:0], mosi_sync}`, `bit_cnt <= 7`, move to NEXT.
    - `sclk` fall: if `bit_cnt != 7`, `miso <= tx_byte[bit_cnt]`; otherwise no change, so the MSB loaded in LOAD is held.
  - **NEXT** (1 cycle): `wr` = 1 with the completed byte's `address`. `count` increments; `address` increments and wraps from MEMORY_SIZE_IN_BYTES-1 to 0. Then moves to LOAD.
- A `cs_n` rise event in any non-IDLE state:
  - Abort to IDLE.
  - A partial byte is discarded, with no `wr`.
  - `done` pulses one cycle later and `count` holds the whole bytes received.
- If NEXT and a `cs_n` rise coincide, the `wr` still completes and `count` includes that byte.
- `sclk` edges while `cs_n` is high are ignored.

## Timing
- Reset values: `miso` 0, `data_out` 0x00, `wr` 0, `address` 0, `done` 0, `count` 0, `overflow` 0. FSM goes to IDLE, `bit_cnt` = 7.
- Pin-to-event latency: 3 `clk` cycles (2 sync + 1 edge detect).
- Requirement: `sclk` high and low phases are each ≥ 6 `clk` cycles (f_clk ≥ 12·f_sclk).
- Requirement: `cs_n` fall to first `sclk` rise is ≥ 6 `clk` cycles.
- These bounds guarantee LOAD finishes before the next `sclk` fall.
- `wr` asserts 1 cycle after the rise event of bit 0, i.e. 4 `clk` cycles after that pin edge.
- `miso` changes 1 cycle after a fall event, i.e. 4 cycles after the pin edge. It is stable on the next `sclk` rise.
- `done` asserts 1 cycle after the `cs_n` rise event.

## Configuration
- `SPI_TARGET_LIMIT_EN` defined:
  - After MEMORY_SIZE_IN_BYTES bytes in one frame, `address` saturates and `wr` is suppressed.
  - `miso` sends 0xFF for further bytes.
  - `overflow` sets and stays sticky until the next `cs_n` fall event.
  - `count` still counts, saturating at 2^(AW+1)-1.
- Not defined: `address` wraps modulo MEMORY_SIZE_IN_BYTES and `overflow` is tied 0.

## Structure
- Package `spi_pkg`: `spi_target_state_t` enum (IDLE, LOAD, SHIFT, NEXT) and `BIT_MSB` = 3'd7.
- Sub-module `spi_sync`: 2-flop synchronizer plus rise/fall pulse outputs. Instantiated three times (`sclk`, `mosi` without edge outputs, `cs_n`).

## Test plan
- **Reset**: assert `rst` mid-byte → all outputs at reset values within 0 cycles (async); the next frame works normally.
- **Single byte**: `data_in`[0] = 0xA5, controller sends 0x3C, clk = 16× sclk → `miso` shifts 0xA5; one `wr` with `address` 0, `data_out` 0x3C; `done` with `count` 1.
- **Multi-byte**: 3 bytes 0x01, 0x02, 0x03 → `wr` at addresses 0, 1, 2; `miso` returns buffer[0..2]; `count` 3.
- **Abort**: `cs_n` rises after 4 bits of byte 2 → exactly one `wr`, `count` 1, no `wr` for the partial byte.
- **Wrap**: MEMORY_SIZE 4, 6 bytes, macro off → addresses 0,1,2,3,0,1; `overflow` 0.
- **Limit**: same stimulus with `SPI_TARGET_LIMIT_EN` → 4 `wr`s; bytes 5 and 6 read 0xFF on `miso`; `overflow` 1 until the next `cs_n` fall.
